target_tb: RTL and testbench

Behavioural PCI target responder for the user side of the OPCI core's target interface; the counterpart of the simulation master model. Decodes a hit on one base-address region, answers memory reads/writes from a small byte-enabled word memory, and can be programmed to retry the first N transactions or target-abort out-of-range accesses. Lives in the simulation top beside the master model so that both ends of a PCI transaction are exercised inside a single core instance.

---
 rtl/opci_tb_pkg.sv | 25 ++
 rtl/target_mem.sv | 39 +++
 rtl/target_tb.sv | 112 +++++++++++
 tb/tb_target_tb.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/opci_tb_pkg.sv
// Shared definitions for the OPCI simulation models: target state encoding,
// PCI command codes and address-field helpers used by both master and target.
package opci_tb_pkg;

  typedef logic [1:0] tgt_state_t;

  localparam tgt_state_t T_IDLE  = 2'd0;
  localparam tgt_state_t T_XFER  = 2'd1;
  localparam tgt_state_t T_RETRY = 2'd2;
  localparam tgt_state_t T_ABORT = 2'd3;

  localparam logic [3:0] CMD_MEM_RD = 4'h6;
  localparam logic [3:0] CMD_MEM_WR = 4'h7;

  // True when the low 4 KiB offset lies beyond a 2^aw-word window.
  function automatic logic addr_out_of_range(input logic [11:0] offset, input int aw);
    return (offset >> (aw + 2)) != 12'd0;
  endfunction

  // Word index of a byte address.
  function automatic logic [31:0] addr_word(input logic [31:0] addr);
    return {2'b00, addr[31:2]};
  endfunction

endpackage

// File: rtl/target_mem.sv
// Byte-laned 2^AW x 32 register file: active-low byte write enables,
// asynchronous read, synchronous clear on reset.
module target_mem
  import opci_tb_pkg::*;
#(
  parameter int AW = 4
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [3:0]    cbe,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] rd_addr,
  output logic [31:0]   rdata
);

  localparam int DEPTH = 1 << AW;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane [DEPTH];

      always_ff @(posedge CLK) begin
        if (reset) begin
          for (int i = 0; i < DEPTH; i++) begin
            lane[i] <= 8'h00;
          end
        end else if (we && !cbe[gi]) begin
          lane[wr_addr] <= wdata[8*gi +: 8];
        end
      end

      assign rdata[8*gi +: 8] = lane[rd_addr];
    end
  endgenerate

endmodule

// File: rtl/target_tb.sv
// Behavioural PCI target responder: one BAR, small byte-enabled memory,
// programmable initial retries and target abort on out-of-range offsets.
module target_tb
  import opci_tb_pkg::*;
#(
  parameter int BAR_IDX   = 0,
  parameter int AW        = 4,
  parameter int RETRY_CNT = 0
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic [31:0] adio_out,
  output logic [31:0] adio_in,
  input  logic        addr_vld,
  input  logic [7:0]  base_hit,
  input  logic        s_wrdn,
  input  logic        s_data,
  input  logic        s_data_vld,
  input  logic [3:0]  s_cbe,
  output logic        s_ready,
  output logic        s_term,
  output logic        s_abort,
  output logic [15:0] xfer_cnt
);

  localparam int RW = (RETRY_CNT > 0) ? $clog2(RETRY_CNT + 1) : 1;

  tgt_state_t    state_reg, state_next;
  logic [AW-1:0] ptr_reg;
  logic          wr_reg;
  logic [RW-1:0] rty_left_reg;
  logic [15:0]   xfer_cnt_reg;
  logic          s_data_q_reg;

  logic          addr_hit;
  logic          out_of_range;
  logic          data_fall;
  logic          xfer_now;
  logic [31:0]   rdata;
  logic          unused_hit;

  assign addr_hit     = addr_vld & base_hit[BAR_IDX];
  assign out_of_range = addr_out_of_range(adio_out[11:0], AW);
  assign data_fall    = s_data_q_reg & ~s_data;
  assign xfer_now     = (state_reg == T_XFER) & s_data_vld;
  assign unused_hit   = ^base_hit;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      T_IDLE: begin
        if (addr_hit) begin
          if (out_of_range)
            state_next = T_ABORT;
          else if (rty_left_reg != '0)
            state_next = T_RETRY;
          else
            state_next = T_XFER;
        end
      end
      default: begin
        if (data_fall)
          state_next = T_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_reg    <= T_IDLE;
      ptr_reg      <= '0;
      wr_reg       <= 1'b0;
      rty_left_reg <= RW'(RETRY_CNT);
      xfer_cnt_reg <= 16'h0000;
      s_data_q_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      s_data_q_reg <= s_data;
      if (state_reg == T_IDLE && addr_hit) begin
        ptr_reg <= adio_out[AW+1:2];
        wr_reg  <= s_wrdn;
        // Only a transaction that actually lands in T_RETRY consumes a retry.
        if (!out_of_range && rty_left_reg != '0)
          rty_left_reg <= rty_left_reg - 1'b1;
      end else if (xfer_now) begin
        ptr_reg <= ptr_reg + 1'b1;
        if (xfer_cnt_reg != 16'hFFFF)
          xfer_cnt_reg <= xfer_cnt_reg + 16'h0001;
      end
    end
  end

  target_mem #(.AW(AW)) u_mem (
    .CLK     (CLK),
    .reset   (reset),
    .we      (xfer_now & wr_reg),
    .wr_addr (ptr_reg),
    .cbe     (s_cbe),
    .wdata   (adio_out),
    .rd_addr (ptr_reg),
    .rdata   (rdata)
  );

  // Disconnect while sitting on the top word so a burst never wraps.
  assign s_ready  = (state_reg == T_XFER);
  assign s_term   = ((state_reg == T_XFER) && (&ptr_reg)) ||
                    (state_reg == T_RETRY) || (state_reg == T_ABORT);
  assign s_abort  = (state_reg == T_ABORT);
  assign xfer_cnt = xfer_cnt_reg;
  assign adio_in  = ((state_reg == T_XFER) && !wr_reg && s_data) ? rdata : 32'hz;

endmodule

// File: tb/tb_target_tb.sv
// Randomised and directed check of target_tb against a word-array model of
// the target's memory, retry budget and transfer counter.
module tb_target_tb;

  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;
  localparam int BAR   = 2;
  localparam int RTY   = 2;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] adio_out = '0;
  wire  [31:0] adio_in;
  logic        addr_vld = 1'b0;
  logic [7:0]  base_hit = '0;
  logic        s_wrdn = 1'b0;
  logic        s_data = 1'b0;
  logic        s_data_vld = 1'b0;
  logic [3:0]  s_cbe = 4'hF;
  logic        s_ready, s_term, s_abort;
  logic [15:0] xfer_cnt;

  target_tb #(.BAR_IDX(BAR), .AW(AW), .RETRY_CNT(RTY)) dut (
    .CLK        (CLK),
    .reset      (reset),
    .adio_out   (adio_out),
    .adio_in    (adio_in),
    .addr_vld   (addr_vld),
    .base_hit   (base_hit),
    .s_wrdn     (s_wrdn),
    .s_data     (s_data),
    .s_data_vld (s_data_vld),
    .s_cbe      (s_cbe),
    .s_ready    (s_ready),
    .s_term     (s_term),
    .s_abort    (s_abort),
    .xfer_cnt   (xfer_cnt)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  logic [31:0] ref_mem [DEPTH];
  int          ref_rty;
  int          ref_xfer;
  logic [31:0] txd [4];
  logic [3:0]  txc [4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic ref_reset();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
    ref_rty  = RTY;
    ref_xfer = 0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_ready"}, 32'(s_ready), 32'd0);
    check({tag, "_term"},  32'(s_term),  32'd0);
    check({tag, "_abort"}, 32'(s_abort), 32'd0);
  endtask

  // One-cycle data window for retried/aborted transactions, then idle.
  task automatic term_window(input bit is_abort);
    s_data = 1'b1;
    @(posedge CLK); #1;
    check("win_term",  32'(s_term),  32'd1);
    check("win_abort", 32'(s_abort), 32'(is_abort));
    s_data = 1'b0;
    @(posedge CLK); #1;
  endtask

  // Full transaction; rst_at >= 0 asserts reset instead of that data phase.
  task automatic txn(input logic [31:0] addr, input bit wr, input int n,
                     input logic [7:0] hits, input int rst_at);
    bit    hit = hits[BAR];
    bit    oor = (addr[11:0] >> (AW + 2)) != 12'd0;
    int    w   = int'(addr[AW+1:2]);
    int    done = 0;
    string kind;
    adio_out = addr; s_wrdn = wr; base_hit = hits; addr_vld = 1'b1;
    @(posedge CLK); #1;
    addr_vld = 1'b0; adio_out = '0;
    if (!hit) begin
      kind = "ignored";
      check_quiet("miss");
    end else if (oor) begin
      kind = "abort";
      check("abt_ready", 32'(s_ready), 32'd0);
      check("abt_term",  32'(s_term),  32'd1);
      check("abt_abort", 32'(s_abort), 32'd1);
      term_window(1'b1);
    end else if (ref_rty > 0) begin
      kind = "retry";
      ref_rty--;
      check("rty_ready", 32'(s_ready), 32'd0);
      check("rty_term",  32'(s_term),  32'd1);
      check("rty_abort", 32'(s_abort), 32'd0);
      term_window(1'b0);
    end else begin
      kind = wr ? "write" : "read";
      check("xf_ready", 32'(s_ready), 32'd1);
      check("xf_abort", 32'(s_abort), 32'd0);
      s_data = 1'b1;
      for (int k = 0; k < n; k++) begin
        if (k == rst_at) begin
          kind = "reset";
          reset = 1'b1;
          @(posedge CLK); #1;
          reset = 1'b0; s_data = 1'b0;
          ref_reset();
          check_quiet("rst");
          check("rst_cnt", 32'(xfer_cnt), 32'd0);
          break;
        end
        #1;
        check("xf_term", 32'(s_term), 32'(w == DEPTH - 1));
        if (!wr) begin
          check("rdata", adio_in, ref_mem[w]);
          // A hit address strobe mid-transfer must be ignored.
          adio_out = 32'h0000_0040; base_hit = 8'hFF; addr_vld = 1'b1;
        end else begin
          adio_out = txd[k]; s_cbe = txc[k];
        end
        s_data_vld = 1'b1;
        @(posedge CLK); #1;
        s_data_vld = 1'b0; addr_vld = 1'b0; adio_out = '0; s_cbe = 4'hF;
        if (wr)
          for (int b = 0; b < 4; b++)
            if (!txc[k][b]) ref_mem[w][8*b +: 8] = txd[k][8*b +: 8];
        if (ref_xfer < 16'hFFFF) ref_xfer++;
        done++;
        if (w == DEPTH - 1) break;
        w = (w + 1) % DEPTH;
      end
      if (kind != "reset") begin
        check("xf_still_ready", 32'(s_ready), 32'd1);
        s_data = 1'b0;
        @(posedge CLK); #1;
      end
    end
    check_quiet("idle");
    check("xfer_cnt", 32'(xfer_cnt), 32'(ref_xfer));
    $display("txn addr=%h wr=%0d n=%0d hit=%0d kind=%s words=%0d cnt=%0d",
             addr, wr, n, hit, kind, done, xfer_cnt);
  endtask

  initial begin
    ref_reset();
    for (int i = 0; i < 4; i++) begin txd[i] = '0; txc[i] = 4'h0; end
    repeat (2) @(posedge CLK);
    #1 reset = 1'b0;
    check_quiet("reset");
    check("reset_cnt", 32'(xfer_cnt), 32'd0);

    // Retry budget: two retried reads, then a normal read of zeroed memory.
    txn(32'h0000_1008, 1'b0, 1, 8'h04, -1);
    txn(32'h0000_1008, 1'b0, 1, 8'h04, -1);
    txn(32'h0000_1008, 1'b0, 1, 8'h04, -1);

    // Single write then read.
    txd[0] = 32'hDEADBEEF; txc[0] = 4'b0000;
    txn(32'h0000_1008, 1'b1, 1, 8'h04, -1);
    txn(32'h0000_1008, 1'b0, 1, 8'h04, -1);

    // Byte enables.
    txd[0] = 32'h11223344; txc[0] = 4'b0000;
    txn(32'h0000_100C, 1'b1, 1, 8'h04, -1);
    txd[0] = 32'hAABBCCDD; txc[0] = 4'b1010;
    txn(32'h0000_100C, 1'b1, 1, 8'h04, -1);
    txn(32'h0000_100C, 1'b0, 1, 8'h04, -1);

    // Burst disconnect at the top word; word 0 must stay untouched.
    txd[0] = 32'h0E0E0E0E; txd[1] = 32'h0F0F0F0F; txd[2] = 32'hBAD00000; txd[3] = 32'hBAD00001;
    for (int i = 0; i < 4; i++) txc[i] = 4'b0000;
    txn(32'h0000_1038, 1'b1, 4, 8'h04, -1);
    txn(32'h0000_1038, 1'b0, 4, 8'h04, -1);
    txn(32'h0000_1000, 1'b0, 1, 8'h04, -1);

    // Abort, then misses on other BAR bits.
    txn(32'h0000_1040, 1'b1, 1, 8'h04, -1);
    txn(32'h0000_1000, 1'b0, 1, 8'h04, -1);
    txn(32'h0000_1008, 1'b1, 1, 8'hFB, -1);

    for (int t = 0; t < 40; t++) begin
      logic [31:0] a;
      logic [7:0]  h;
      a = {$urandom_range(0, 32'hFFFFF), 12'h000} | (32'($urandom_range(0, DEPTH - 1)) << 2);
      if ($urandom_range(0, 7) == 0) a = a | (32'($urandom_range(1, 63)) << 6);
      h = 8'($urandom);
      h[BAR] = ($urandom_range(0, 7) != 0);
      for (int i = 0; i < 4; i++) begin txd[i] = $urandom; txc[i] = 4'($urandom); end
      txn(a, 1'($urandom), $urandom_range(1, 4), h, -1);
    end

    // Reset mid-burst, then retries re-armed and memory cleared.
    for (int i = 0; i < 4; i++) begin txd[i] = 32'hC0DE0000 + i; txc[i] = 4'b0000; end
    txn(32'h0000_1000, 1'b1, 4, 8'h04, 2);
    txn(32'h0000_1000, 1'b0, 1, 8'h04, -1);
    txn(32'h0000_1000, 1'b0, 1, 8'h04, -1);
    txn(32'h0000_1000, 1'b0, 2, 8'h04, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
